// File: rtl/float_mul_arbiter_if.sv
// Request/response bundle between execution units, the arbiter and the shared float multiplier core.
interface float_mul_arbiter_if #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned float_width = 32
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*float_width-1:0] a;
    logic [NUM_REQ*float_width-1:0] b;
    logic [NUM_REQ-1:0]             ack;
    logic [float_width-1:0]         out;
    logic                           resp_err;
    logic                           core_req;
    logic [float_width-1:0]         core_a;
    logic [float_width-1:0]         core_b;
    logic                           core_ack;
    logic [float_width-1:0]         core_out;

    modport master (
        output req, a, b, core_ack, core_out,
        input  ack, out, resp_err, core_req, core_a, core_b
    );

    modport slave (
        input  req, a, b, core_ack, core_out,
        output ack, out, resp_err, core_req, core_a, core_b
    );
endinterface

// File: rtl/float_mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle float multiplier among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining FLOAT_MUL_ARB_TIMEOUT_EN.
module float_mul_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned float_width    = 32
) (
    input logic                clk,
    input logic                rst_n,
    float_mul_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("float_mul_arbiter: NUM_REQ and TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [float_width-1:0] out_q, out_d;
    logic                   core_req_q, core_req_d;
    logic [float_width-1:0] core_a_q, core_a_d;
    logic [float_width-1:0] core_b_q, core_b_d;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       cand;
    logic [float_width-1:0] win_a, win_b;

`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            resp_err_q, resp_err_d;
    logic            wd_expired;

    assign wd_expired = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_a = bus.a[i*float_width +: float_width];
                win_b = bus.b[i*float_width +: float_width];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        ack_d      = ack_q;
        out_d      = out_q;
        core_req_d = core_req_q;
        core_a_d   = core_a_q;
        core_b_d   = core_b_q;
`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
        wd_cnt_d   = wd_cnt_q;
        resp_err_d = resp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d    = win_idx;
                    core_a_d   = win_a;
                    core_b_d   = win_b;
                    core_req_d = 1'b1;
                    rr_ptr_d   = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
                    state_d    = WAIT;
`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
                    wd_cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                core_req_d = 1'b0;
                // A core_ack coinciding with watchdog expiry is treated as a normal completion.
                if (bus.core_ack) begin
                    out_d          = bus.core_out;
                    ack_d          = '0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = RESP;
                end
`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    out_d          = float_width'(32'h7fc0_0000);
                    resp_err_d     = 1'b1;
                    ack_d          = '0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                ack_d   = '0;
                out_d   = '0;
                state_d = IDLE;
`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
                resp_err_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            out_q      <= '0;
            core_req_q <= 1'b0;
            core_a_q   <= '0;
            core_b_q   <= '0;
`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
            wd_cnt_q   <= '0;
            resp_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            out_q      <= out_d;
            core_req_q <= core_req_d;
            core_a_q   <= core_a_d;
            core_b_q   <= core_b_d;
`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
            wd_cnt_q   <= wd_cnt_d;
            resp_err_q <= resp_err_d;
`endif
        end
    end

    assign bus.ack      = ack_q;
    assign bus.out      = out_q;
    assign bus.core_req = core_req_q;
    assign bus.core_a   = core_a_q;
    assign bus.core_b   = core_b_q;
`ifdef FLOAT_MUL_ARB_TIMEOUT_EN
    assign bus.resp_err = resp_err_q;
`else
    assign bus.resp_err = 1'b0;
`endif

endmodule
